// File: rtl/sd_port_arbiter_pkg.sv
// Shared constants for the SD sector-channel arbiter.
// FSM state encodings and sector geometry.
package sd_port_arbiter_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_XFER  = 2'd2;
  localparam logic [1:0] ST_REL   = 2'd3;

  localparam int SD_SECTOR_BYTES = 512;
  localparam int SD_ADDR_W       = $clog2(SD_SECTOR_BYTES);
  localparam int TMO_W           = 21;

endpackage

// File: rtl/sd_port_arbiter_if.sv
// Host SD sector port bundle.
// master = arbiter side, slave = host SD controller side.
interface sd_port_arbiter_if #(
  parameter int LBA_W = 32
);
  import sd_port_arbiter_pkg::*;

  logic [LBA_W-1:0]     lba;
  logic                 rd;
  logic                 wr;
  logic                 busy;
  logic                 done;
  logic [SD_ADDR_W-1:0] addr;
  logic                 data_en;
  logic [7:0]           data_in;
  logic [7:0]           data_out;

  modport master (
    output lba, rd, wr, data_out,
    input  busy, done, addr, data_en, data_in
  );

  modport slave (
    input  lba, rd, wr, data_out,
    output busy, done, addr, data_en, data_in
  );

endinterface

// File: rtl/sd_port_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request
// at or after the pointer, wrapping NREQ-1 -> 0.
module sd_rr_pick #(
  parameter int NREQ = 3,
  parameter int OW   = 2
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [OW-1:0]   i_ptr,
  output logic [OW-1:0]   o_idx,
  output logic            o_valid
);

  always_comb begin
    o_idx   = '0;
    o_valid = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      int j;
      j = (int'(i_ptr) + k) % NREQ;
      if (!o_valid && i_req[j]) begin
        o_idx   = OW'(j);
        o_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sd_port_arbiter.sv
// Round-robin sharing of one host SD sector channel among NREQ clients.
// Optional ISSUE-phase watchdog enabled by SD_ARB_TIMEOUT_EN.
module sd_port_arbiter
  import sd_port_arbiter_pkg::*;
#(
  parameter int NREQ           = 3,
  parameter int LBA_W          = 32,
  parameter int TIMEOUT_CYCLES = 1048576,
  localparam int OW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       i_cl_rd,
  input  logic [NREQ-1:0]       i_cl_wr,
  input  logic [NREQ*LBA_W-1:0] i_cl_lba,
  input  logic [NREQ*8-1:0]     i_cl_data_out,
  output logic [NREQ-1:0]       o_cl_busy,
  output logic [NREQ-1:0]       o_cl_done,
  output logic [NREQ-1:0]       o_cl_data_en,
  output logic [NREQ-1:0]       o_cl_err,
  output logic [SD_ADDR_W-1:0]  o_sd_addr,
  output logic [7:0]            o_sd_data_in,
  sd_port_arbiter_if.master     sd,
  output logic [OW-1:0]         o_owner
);

  logic [1:0]       r_state;
  logic [OW-1:0]    r_owner;
  logic [OW-1:0]    r_ptr;
  logic [LBA_W-1:0] r_lba;
  logic             r_rd;
  logic             r_wr;

  logic [OW-1:0]    w_pick;
  logic             w_pick_v;
  logic [OW-1:0]    w_nxt;
  logic [NREQ-1:0]  w_oh;
  logic             w_tmo;
  logic [LBA_W-1:0] w_lba  [NREQ];
  logic [7:0]       w_dout [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_cl
    assign w_lba[i]  = i_cl_lba[i*LBA_W +: LBA_W];
    assign w_dout[i] = i_cl_data_out[i*8 +: 8];
    assign w_oh[i]   = (r_owner == OW'(i));
  end

  sd_rr_pick #(
    .NREQ (NREQ),
    .OW   (OW)
  ) u_pick (
    .i_req   (i_cl_rd | i_cl_wr),
    .i_ptr   (r_ptr),
    .o_idx   (w_pick),
    .o_valid (w_pick_v)
  );

  assign w_nxt = (r_owner == OW'(NREQ-1))
               ? '0 : r_owner + OW'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_owner <= '0;
      r_ptr   <= '0;
      r_lba   <= '0;
      r_rd    <= 1'b0;
      r_wr    <= 1'b0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (!sd.busy && w_pick_v) begin
            r_owner <= w_pick;
            r_lba   <= w_lba[w_pick];
            r_rd    <= i_cl_rd[w_pick];
            r_wr    <= i_cl_wr[w_pick] & ~i_cl_rd[w_pick];
            r_state <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (sd.busy) begin
            r_rd    <= 1'b0;
            r_wr    <= 1'b0;
            r_state <= ST_XFER;
          end else if (w_tmo) begin
            r_rd    <= 1'b0;
            r_wr    <= 1'b0;
            r_ptr   <= w_nxt;
            r_state <= ST_IDLE;
          end
        end
        ST_XFER: begin
          if (!sd.busy) r_state <= ST_REL;
        end
        default: begin
          r_ptr   <= w_nxt;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef SD_ARB_TIMEOUT_EN
  logic [TMO_W-1:0] r_tmo;
  logic [NREQ-1:0]  r_err;

  assign w_tmo = !sd.busy
              && (r_tmo == TMO_W'(TIMEOUT_CYCLES-1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tmo <= '0;
      r_err <= '0;
    end else begin
      r_tmo <= (r_state == ST_ISSUE) ? r_tmo + 1'b1 : '0;
      r_err <= (r_state == ST_ISSUE && w_tmo) ? w_oh : '0;
    end
  end

  assign o_cl_err = r_err;
`else
  assign w_tmo    = 1'b0;
  assign o_cl_err = '0;
`endif

  // non-owners stay busy for the whole grant so they never race
  assign o_cl_busy = (r_state == ST_IDLE)
                   ? {NREQ{sd.busy}}
                   : (~w_oh | {NREQ{r_state == ST_XFER || sd.busy}});

  assign o_cl_done    = (r_state == ST_REL) ? w_oh : '0;
  assign o_cl_data_en = (sd.data_en && r_state == ST_XFER)
                      ? w_oh : '0;

  assign sd.lba       = r_lba;
  assign sd.rd        = r_rd;
  assign sd.wr        = r_wr;
  assign sd.data_out  = w_dout[r_owner];
  assign o_sd_addr    = sd.addr;
  assign o_sd_data_in = sd.data_in;
  assign o_owner      = r_owner;

endmodule
